// File: rtl/ahb_req_arbiter.sv
// Arbitrates the core's ifetch and data request ports onto a single AHB-Lite bus master.
// Data has priority, a starvation counter bounds how long ifetch waits, and a watchdog flags hung transfers.
module ahb_req_arbiter #(
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_iread,
  input  logic [31:0] cpu_iaddr,
  input  logic        cpu_dread,
  input  logic [1:0]  cpu_dwrite,
  input  logic [31:0] cpu_daddr,
  input  logic [31:0] cpu_dstore,
  output logic        cpu_ihit,
  output logic [31:0] cpu_iload,
  output logic        cpu_dhit,
  output logic [31:0] cpu_dload,
  output logic        m_iread,
  output logic [31:0] m_iaddr,
  output logic        m_dread,
  output logic [1:0]  m_dwrite,
  output logic [31:0] m_daddr,
  output logic [31:0] m_dstore,
  input  logic        m_ihit,
  input  logic [31:0] m_iload,
  input  logic        m_dhit,
  input  logic [31:0] m_dload,
  output logic        err_timeout
);

  localparam int SW = $clog2(MAX_STARVE + 2);
  localparam int WW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wdog;
  logic [31:0]   iaddr_q, daddr_q, dstore_q;
  logic          dread_q;
  logic [1:0]    dwrite_q;
  logic          d_req, d_win, i_win, done;

  always_comb begin
    d_req    = cpu_dread | (|cpu_dwrite);
    d_win    = 1'b0;
    i_win    = 1'b0;
    done     = 1'b0;
    state_nx = state;
    case (state)
      IDLE: begin
        d_win = d_req && (!cpu_iread || (int'(starve_cnt) < MAX_STARVE));
        i_win = !d_win && cpu_iread;
        if (d_win)
          state_nx = D_BUSY;
        else if (i_win)
          state_nx = I_BUSY;
      end
      I_BUSY: done = m_ihit;
      D_BUSY: done = m_dhit;
      default: state_nx = IDLE;
    endcase
    if (done)
      state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      wdog        <= '0;
      err_timeout <= 1'b0;
      iaddr_q     <= '0;
      daddr_q     <= '0;
      dstore_q    <= '0;
      dread_q     <= 1'b0;
      dwrite_q    <= 2'b00;
    end else begin
      state <= state_nx;
      if (d_win) begin
        daddr_q  <= cpu_daddr;
        dstore_q <= cpu_dstore;
        dread_q  <= cpu_dread;
        // A load with a store size also set is treated as a plain load
        dwrite_q <= cpu_dread ? 2'b00 : cpu_dwrite;
        if (!cpu_iread)
          starve_cnt <= '0;
        else if (int'(starve_cnt) < MAX_STARVE)
          starve_cnt <= starve_cnt + SW'(1);
      end
      if (i_win) begin
        iaddr_q    <= cpu_iaddr;
        starve_cnt <= '0;
      end
      if (state_nx == IDLE)
        wdog <= '0;
      else if (state != IDLE && wdog != WW'(TIMEOUT))
        wdog <= wdog + WW'(1);
      if (state != IDLE && wdog == WW'(TIMEOUT))
        err_timeout <= 1'b1;
    end
  end

  always_comb begin
    m_iread   = (state == I_BUSY);
    m_iaddr   = m_iread ? iaddr_q : '0;
    m_dread   = (state == D_BUSY) && dread_q;
    m_dwrite  = (state == D_BUSY) ? dwrite_q : 2'b00;
    m_daddr   = (state == D_BUSY) ? daddr_q : '0;
    m_dstore  = (state == D_BUSY) ? dstore_q : '0;
    cpu_ihit  = (state == I_BUSY) && m_ihit;
    cpu_iload = cpu_ihit ? m_iload : '0;
    cpu_dhit  = (state == D_BUSY) && m_dhit;
    cpu_dload = (cpu_dhit && dread_q) ? m_dload : '0;
  end

endmodule
